fs_accel_pool_win_ctrl: RTL

Parametrised window-pooling controller for the accelerator's element-wise stage. It is the generalised successor of the fixed 2x2 max-pool sequencer, and sits between the quant/activation output stream and the pooling buffer datapath. It counts a raster-ordered stream of activations (column, row, channel) and issues one registered command per accepted element to a bank of MAX_PW pooling buffers: load, accumulate or ignore, plus an emit flag with output address. It supports K x K windows with stride K (K = 1..MAX_K), odd-size edge trimming, multi-channel planes, backpressure, and an optional average mode.

---
 rtl/fs_accel_pkg.sv | 7 +
 rtl/fs_accel_pool_win_cnt.sv | 73 +++++++
 rtl/fs_accel_pool_win_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fs_accel_pkg.sv
// fs_accel_pkg: shared pooling command encoding and window-controller states.
package fs_accel_pkg;
  localparam logic [1:0] POOL_OP_IGNORE = 2'd0;
  localparam logic [1:0] POOL_OP_LOAD = 2'd1;
  localparam logic [1:0] POOL_OP_ACC = 2'd2;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} pool_state_e;
endpackage

// File: rtl/fs_accel_pool_win_cnt.sv
// fs_accel_pool_win_cnt: raster position counters (col/row/ch) with in-window offsets,
// window indices and the wrap/trim flags the controller needs, all without a divider.
module fs_accel_pool_win_cnt
  import fs_accel_pkg::*;
#(
  parameter int DIM_W = 16,
  parameter int CH_W = 12
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             adv_i,
  input  logic [2:0]       k_i,
  input  logic [DIM_W-1:0] w_i,
  input  logic [DIM_W-1:0] h_i,
  input  logic [DIM_W-1:0] pw_i,
  input  logic [DIM_W-1:0] ph_i,
  input  logic [CH_W-1:0]  c_i,
  output logic [DIM_W-1:0] gx_o,
  output logic             first_o,
  output logic             emit_o,
  output logic             trim_o,
  output logic             row_step_o,
  output logic             plane_step_o,
  output logic             last_o
);
  logic [DIM_W-1:0] col_q, row_q, gx_q, gy_q;
  logic [CH_W-1:0] ch_q;
  logic [2:0] kx_q, ky_q;
  logic col_last, row_last, ch_last, kx_last, ky_last;
  assign col_last = col_q == w_i - 1'b1;
  assign row_last = row_q == h_i - 1'b1;
  assign ch_last = ch_q == c_i - 1'b1;
  assign kx_last = kx_q == k_i - 3'd1;
  assign ky_last = ky_q == k_i - 3'd1;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q <= '0;
      row_q <= '0;
      gx_q <= '0;
      gy_q <= '0;
      kx_q <= '0;
      ky_q <= '0;
      ch_q <= '0;
    end else if (clr_i) begin
      col_q <= '0;
      row_q <= '0;
      gx_q <= '0;
      gy_q <= '0;
      kx_q <= '0;
      ky_q <= '0;
      ch_q <= '0;
    end else if (adv_i) begin
      col_q <= col_last ? '0 : col_q + 1'b1;
      kx_q <= (col_last || kx_last) ? '0 : kx_q + 3'd1;
      gx_q <= col_last ? '0 : kx_last ? gx_q + 1'b1 : gx_q;
      if (col_last) begin
        row_q <= row_last ? '0 : row_q + 1'b1;
        ky_q <= (row_last || ky_last) ? '0 : ky_q + 3'd1;
        gy_q <= row_last ? '0 : ky_last ? gy_q + 1'b1 : gy_q;
        if (row_last) ch_q <= ch_last ? '0 : ch_q + 1'b1;
      end
    end
  end
  // Trimming compares window indices against the pooled size, so no PW*K product is needed.
  assign gx_o = gx_q;
  assign first_o = kx_q == 3'd0 && ky_q == 3'd0;
  assign emit_o = kx_last && ky_last;
  assign trim_o = gx_q >= pw_i || gy_q >= ph_i;
  assign row_step_o = col_last && ky_last;
  assign plane_step_o = col_last && row_last;
  assign last_o = col_last && row_last && ch_last;
endmodule

// File: rtl/fs_accel_pool_win_ctrl.sv
// fs_accel_pool_win_ctrl: KxK/stride-K pooling sequencer issuing one registered command per element.
// Optional average mode is enabled with POOL_AVG_EN.
module fs_accel_pool_win_ctrl
  import fs_accel_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DIM_W = 16,
  parameter int CH_W = 12,
  parameter int MAX_K = 4,
  parameter int MAX_PW = 16,
  localparam int SEL_W = $clog2(MAX_PW)
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              enb_i,
  input  logic              start_i,
  input  logic [DIM_W-1:0]  cfg_w_i,
  input  logic [DIM_W-1:0]  cfg_h_i,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [2:0]        cfg_k_i,
  input  logic              cfg_avg_i,
  input  logic [ADDR_W-1:0] cfg_o_base_i,
  input  logic [ADDR_W-1:0] cfg_o_ch_stride_i,
  input  logic              in_valid_i,
  output logic              in_rdy_o,
  output logic              cmd_valid_o,
  input  logic              cmd_rdy_i,
  output logic [1:0]        cmd_op_o,
  output logic [SEL_W-1:0]  cmd_sel_o,
  output logic              cmd_emit_o,
  output logic              cmd_avg_o,
  output logic [5:0]        cmd_div_o,
  output logic [ADDR_W-1:0] cmd_o_addr_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);
  pool_state_e state_q;
  logic [DIM_W-1:0] w_q, h_q, pw_q, ph_q, pw_c, ph_c, gx;
  logic [CH_W-1:0] c_q;
  logic [2:0] k_q;
  logic [ADDR_W-1:0] stride_q, plane_base_q, row_base_q, cmd_o_addr_q;
  logic [1:0] cmd_op_q;
  logic [SEL_W-1:0] cmd_sel_q;
  logic [5:0] cmd_div_q, cmd_div_c;
  logic cmd_valid_q, cmd_emit_q, cmd_avg_q, cmd_avg_c, done_q, err_q;
  logic k_ok, legal_c, empty_c, start_ok, accept;
  logic first, emit, trim, row_step, plane_step, last;
  assign k_ok = cfg_k_i != 3'd0 && int'(cfg_k_i) <= MAX_K;
  assign pw_c = k_ok ? cfg_w_i / DIM_W'(cfg_k_i) : '0;
  assign ph_c = k_ok ? cfg_h_i / DIM_W'(cfg_k_i) : '0;
  assign legal_c = k_ok && int'(pw_c) <= MAX_PW;
  assign empty_c = cfg_w_i == '0 || cfg_h_i == '0 || cfg_ch_i == '0;
  assign start_ok = enb_i && start_i && state_q == ST_IDLE && legal_c;
  assign in_rdy_o = state_q == ST_RUN && enb_i && (!cmd_valid_q || cmd_rdy_i);
  assign accept = in_valid_i && in_rdy_o;
  fs_accel_pool_win_cnt #(.DIM_W(DIM_W), .CH_W(CH_W)) u_cnt (
    .clk_i(clk_i),
    .rst_ni(resetn_i),
    .clr_i(start_ok),
    .adv_i(accept),
    .k_i(k_q),
    .w_i(w_q),
    .h_i(h_q),
    .pw_i(pw_q),
    .ph_i(ph_q),
    .c_i(c_q),
    .gx_o(gx),
    .first_o(first),
    .emit_o(emit),
    .trim_o(trim),
    .row_step_o(row_step),
    .plane_step_o(plane_step),
    .last_o(last)
  );
`ifdef POOL_AVG_EN
  logic avg_q;
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) avg_q <= 1'b0;
    else if (start_ok) avg_q <= cfg_avg_i;
  end
  assign cmd_avg_c = avg_q;
  assign cmd_div_c = 6'(k_q) * 6'(k_q);
`else
  logic unused_avg;
  assign unused_avg = cfg_avg_i;
  assign cmd_avg_c = 1'b0;
  assign cmd_div_c = '0;
`endif
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= ST_IDLE;
      w_q <= '0;
      h_q <= '0;
      pw_q <= '0;
      ph_q <= '0;
      c_q <= '0;
      k_q <= '0;
      stride_q <= '0;
      plane_base_q <= '0;
      row_base_q <= '0;
      cmd_valid_q <= 1'b0;
      cmd_op_q <= POOL_OP_IGNORE;
      cmd_sel_q <= '0;
      cmd_emit_q <= 1'b0;
      cmd_avg_q <= 1'b0;
      cmd_div_q <= '0;
      cmd_o_addr_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else if (enb_i) begin
      done_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (start_i) begin
          err_q <= !legal_c;
          if (legal_c) begin
            w_q <= cfg_w_i;
            h_q <= cfg_h_i;
            pw_q <= pw_c;
            ph_q <= ph_c;
            c_q <= cfg_ch_i;
            k_q <= cfg_k_i;
            stride_q <= cfg_o_ch_stride_i;
            plane_base_q <= cfg_o_base_i;
            row_base_q <= '0;
            state_q <= empty_c ? ST_DONE : ST_RUN;
            done_q <= empty_c;
          end
        end
        ST_RUN: if (accept && last) state_q <= ST_DRAIN;
        ST_DRAIN: if (!cmd_valid_q || cmd_rdy_i) begin
          state_q <= ST_DONE;
          done_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
      if (accept) begin
        cmd_valid_q <= 1'b1;
        cmd_op_q <= trim ? POOL_OP_IGNORE : first ? POOL_OP_LOAD : POOL_OP_ACC;
        cmd_sel_q <= trim ? '0 : gx[SEL_W-1:0];
        cmd_emit_q <= !trim && emit;
        cmd_o_addr_q <= (!trim && emit) ? plane_base_q + row_base_q + ADDR_W'(gx) : '0;
        cmd_avg_q <= cmd_avg_c;
        cmd_div_q <= cmd_div_c;
        // Address bases advance with the element just consumed, ready for the next one.
        plane_base_q <= plane_step ? plane_base_q + stride_q : plane_base_q;
        row_base_q <= plane_step ? '0 : row_step ? row_base_q + ADDR_W'(pw_q) : row_base_q;
      end else if (cmd_rdy_i) begin
        cmd_valid_q <= 1'b0;
      end
    end
  end
  assign cmd_valid_o = cmd_valid_q;
  assign cmd_op_o = cmd_op_q;
  assign cmd_sel_o = cmd_sel_q;
  assign cmd_emit_o = cmd_emit_q;
  assign cmd_avg_o = cmd_avg_q;
  assign cmd_div_o = cmd_div_q;
  assign cmd_o_addr_o = cmd_o_addr_q;
  assign busy_o = state_q != ST_IDLE;
  assign done_o = done_q;
  assign err_o = err_q;
endmodule
